// File: rtl/test_mailbox_pkg.sv
// Shared SoC definitions for the test mailbox: register offsets and STATUS layout.
package test_mailbox_pkg;

  // Word offsets within the 16-byte register window (mem_addr[3:2]).
  typedef enum logic [1:0] {
    REG_TOHOST = 2'd0,
    REG_CHAR   = 2'd1,
    REG_STATUS = 2'd2,
    REG_CLEAR  = 2'd3
  } mbox_reg_e;

  // STATUS bit positions, shared with firmware headers and benches.
  localparam int unsigned STATUS_DONE_BIT     = 0;
  localparam int unsigned STATUS_PASS_BIT     = 1;
  localparam int unsigned STATUS_EMPTY_BIT    = 2;
  localparam int unsigned STATUS_FULL_BIT     = 3;
  localparam int unsigned STATUS_OVERFLOW_BIT = 4;

  // Field order matches the bit positions above (first field is the MSB).
  typedef struct packed {
    logic overflow;
    logic full;
    logic empty;
    logic pass;
    logic done;
  } mbox_status_t;

  function automatic logic [31:0] pack_status(input mbox_status_t s);
    return {27'b0, s};
  endfunction

endpackage

// File: rtl/test_mailbox_sync_fifo.sv
// Synchronous circular-buffer FIFO (the mailbox's sync_fifo) with flush.
// Head data is combinational from storage; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module test_mailbox_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the buffer and wins over traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; entries need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/test_mailbox.sv
// Memory-mapped test-result mailbox: sticky pass/fail verdict plus a debug
// character FIFO drained through a valid/ready side port.
module test_mailbox
  import test_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready
);

  logic         sel;
  mbox_reg_e    reg_off;
  logic         wr_tohost;
  logic         wr_char;
  logic         wr_clear;
  logic         done_q;
  logic         pass_q;
  logic [30:0]  code_q;
  logic         ovf_q;
  logic         ready_q;
  logic [31:0]  rdata_q;
  logic [31:0]  rd_mux;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         unused_addr_bits;
  mbox_status_t status;

  assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = mbox_reg_e'(mem_addr[3:2]);
  assign wr_tohost = sel && mem_we && (reg_off == REG_TOHOST);
  assign wr_char   = sel && mem_we && (reg_off == REG_CHAR);
  assign wr_clear  = sel && mem_we && (reg_off == REG_CLEAR);
  assign fifo_pop  = char_valid && char_ready;

  // Byte lanes are not decoded; word offset alone selects the register.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign status = '{overflow: ovf_q, full: fifo_full, empty: fifo_empty,
                    pass: pass_q, done: done_q};

  test_mailbox_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (wr_clear),
    .push    (wr_char),
    .pop     (char_ready),
    .wdata   (mem_wdata[7:0]),
    .rdata   (char_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign char_valid = !fifo_empty;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = code_q;
  assign mem_ready  = ready_q;
  assign mem_rdata  = rdata_q;

  // Read data selection from the state visible in the request cycle.
  always_comb begin
    rd_mux = '0;
    case (reg_off)
      REG_TOHOST: rd_mux = {code_q, done_q};
      REG_STATUS: rd_mux = pack_status(status);
      default:    rd_mux = '0;
    endcase
  end

  // Registered single-cycle bus response; read data is zero outside a read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= sel;
      rdata_q <= (sel && !mem_we) ? rd_mux : '0;
    end
  end

  // Sticky verdict: only the first write with bit 0 set is latched until CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      code_q <= '0;
    end else if (wr_clear) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      code_q <= '0;
    end else if (wr_tohost && mem_wdata[0] && !done_q) begin
      done_q <= 1'b1;
      pass_q <= (mem_wdata == 32'h1);
      code_q <= mem_wdata[31:1];
    end
  end

  // Overflow flags a CHAR write dropped because the FIFO stayed full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (wr_clear) begin
      ovf_q <= 1'b0;
    end else if (wr_char && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_mailbox.sv
// Self-checking bench for test_mailbox: directed test-plan sequences followed by
// randomized traffic, checked by a queue-based reference model and scoreboard.
module tb_test_mailbox;
  import test_mailbox_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;

  test_mailbox #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: verdict fields, overflow flag, character queue, and
  // the scoreboard of expected bus responses.
  bit          m_done;
  bit          m_pass;
  bit   [30:0] m_code;
  bit          m_ovf;
  byte unsigned m_q[$];
  logic [31:0] exp_q[$];

  // Directed reads may carry an explicit expected value.
  bit          dir_en;
  logic [31:0] dir_val;

  logic [31:0] m_rd;
  logic [31:0] m_exp;
  logic [1:0]  m_off;
  bit          m_sel;
  bit          m_pop;

  // Monitor + model: compare what the DUT shows now, then apply the effect of
  // the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_done = 0; m_pass = 0; m_code = '0; m_ovf = 0;
      m_q.delete();
      exp_q.delete();
      check("reset bus", {mem_ready, mem_rdata}, '0);
      check("reset flags", {done, pass, fail_code, char_valid}, '0);
    end else begin
      if (mem_ready) begin
        if (exp_q.size() == 0) check("unexpected mem_ready", 1, 0);
        else begin
          m_exp = exp_q.pop_front();
          check("mem_rdata", mem_rdata, m_exp);
        end
      end else if (exp_q.size() != 0) begin
        check("mem_ready latency", 0, 1);
        exp_q.delete();
      end else begin
        check("idle mem_rdata", mem_rdata, 0);
      end

      check("flags {done,pass,code,cvalid}", {done, pass, fail_code, char_valid},
            {m_done, m_pass, m_code, (m_q.size() != 0)});
      if (m_q.size() != 0) check("char_data", char_data, m_q[0]);

      m_pop = char_ready && (m_q.size() != 0);
      m_sel = mem_valid && (mem_addr[31:4] == BASE[31:4]);
      m_off = mem_addr[3:2];
      if (m_sel) begin
        m_rd = '0;
        if (!mem_we) begin
          if (m_off == 2'd0) m_rd = {m_code, m_done};
          else if (m_off == 2'd2)
            m_rd = {27'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0), m_pass, m_done};
        end
        exp_q.push_back(dir_en ? dir_val : m_rd);
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_sel && mem_we) begin
        case (m_off)
          2'd0: if (mem_wdata[0] && !m_done) begin
            m_done = 1;
            m_pass = (mem_wdata == 32'h1);
            m_code = mem_wdata[31:1];
          end
          2'd1: if (m_q.size() < DEPTH) m_q.push_back(mem_wdata[7:0]);
                else m_ovf = 1;
          2'd3: begin
            m_done = 0; m_pass = 0; m_code = '0; m_ovf = 0;
            m_q.delete();
          end
          default: ;
        endcase
      end
    end
  end

  task automatic drive(input bit v, input bit we, input logic [31:0] addr,
                       input logic [31:0] d, input bit cr, input bit de,
                       input logic [31:0] dv);
    @(posedge clk);
    #1;
    mem_valid  = v;
    mem_we     = we;
    mem_addr   = addr;
    mem_wdata  = d;
    char_ready = cr;
    dir_en     = de;
    dir_val    = dv;
  endtask

  task automatic wr(input mbox_reg_e off, input logic [31:0] d, input bit cr = 0);
    drive(1'b1, 1'b1, BASE + {28'b0, off, 2'b00}, d, cr, 1'b0, '0);
  endtask

  task automatic rd_chk(input mbox_reg_e off, input logic [31:0] e, input bit cr = 0);
    drive(1'b1, 1'b0, BASE + {28'b0, off, 2'b00}, '0, cr, 1'b1, e);
  endtask

  task automatic idle(input int n, input bit cr = 0);
    repeat (n) drive(1'b0, 1'b0, '0, '0, cr, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  logic [31:0] r_addr;
  logic [31:0] r_data;
  int          r;

  initial begin
    reset_n = 1'b0;
    mem_valid = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    char_ready = 0; dir_en = 0; dir_val = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // Passing verdict, read back.
    wr(REG_TOHOST, 32'h1);
    idle(1);
    rd_chk(REG_TOHOST, 32'h0000_0001);
    idle(2);

    // Failing verdict is sticky against a later pass write.
    wr(REG_CLEAR, '0);
    wr(REG_TOHOST, 32'h0000_0007);
    wr(REG_TOHOST, 32'h1);
    rd_chk(REG_TOHOST, 32'h0000_0007);
    rd_chk(REG_STATUS, 32'h0000_0005);
    idle(1);

    // 'O','K' held, then drained.
    wr(REG_CLEAR, '0);
    wr(REG_CHAR, 32'h4F);
    wr(REG_CHAR, 32'h4B);
    idle(2);
    check("held head", {char_valid, char_data}, {1'b1, 8'h4F});
    rd_chk(REG_STATUS, 32'h0000_0000);
    idle(3, 1'b1);
    idle(1);

    // Overflow: 9 pushes into a depth-8 FIFO.
    for (int i = 0; i < 9; i++) wr(REG_CHAR, 32'h30 + 32'(i));
    rd_chk(REG_STATUS, 32'h0000_0018);
    idle(12, 1'b1);
    idle(1);

    // Full FIFO with simultaneous push and pop.
    wr(REG_CLEAR, '0);
    for (int i = 0; i < 8; i++) wr(REG_CHAR, 32'h60 + 32'(i));
    wr(REG_CHAR, 32'hA0, 1'b1);
    rd_chk(REG_STATUS, 32'h0000_0008);
    idle(12, 1'b1);
    idle(1);

    // CLEAR after failing verdict with bytes buffered; unselected write ignored.
    wr(REG_CLEAR, '0);
    wr(REG_TOHOST, 32'h0000_0005);
    for (int i = 0; i < 3; i++) wr(REG_CHAR, 32'h41 + 32'(i));
    wr(REG_CLEAR, '0);
    rd_chk(REG_STATUS, 32'h0000_0004);
    drive(1'b1, 1'b1, 32'h0000_2000, 32'h1, 1'b0, 1'b0, '0);
    rd_chk(REG_TOHOST, 32'h0);

    // Reset during an in-flight read response.
    rd_chk(REG_STATUS, 32'h0000_0004);
    @(posedge clk);
    #2;
    check("in-flight mem_ready", mem_ready, 1);
    reset_n   = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("mem_ready dropped by reset", {mem_ready, mem_rdata}, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        idle(1, 1'($urandom_range(0, 1)));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      r_addr = BASE + 32'h4;
        else if (r < 60) r_addr = BASE;
        else if (r < 85) r_addr = BASE + 32'h8;
        else if (r < 90) r_addr = BASE + 32'hC;
        else begin
          r_addr = $urandom;
          if (r_addr[31:4] == BASE[31:4]) r_addr = r_addr ^ 32'h0000_0100;
        end
        if (r < 90) r_addr = r_addr + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0:       r_data = 32'h1;
          1:       r_data = $urandom | 32'h1;
          default: r_data = $urandom;
        endcase
        drive(1'b1, 1'($urandom_range(0, 1)), r_addr, r_data,
              1'($urandom_range(0, 1)), 1'b0, '0);
      end
    end
    idle(3);
    check("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_mailbox.md
# test_mailbox

Memory-mapped test-result mailbox on the SoC data bus. The program under test writes its verdict and optional debug characters here, so the bench needs no knowledge of register-file internals. The block latches a pass/fail verdict and buffers characters in a small FIFO. It exposes both on a valid/ready side port that the bench (or a future UART bridge) drains.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window
- FIFO_DEPTH, 8, character FIFO entries; power of two, ≥2

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- mem_valid  input  1  CPU data-bus request
- mem_we  input  1  1 = write, 0 = read
- mem_addr  input  32  byte address
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data, valid with mem_ready
- mem_ready  output  1  single-cycle completion strobe
- done  output  1  verdict latched
- pass  output  1  verdict was pass; meaningful only when done=1
- fail_code  output  31  TOHOST[31:1] of a failing verdict
- char_valid  output  1  FIFO head available
- char_data  output  8  FIFO head byte
- char_ready  input  1  consumer accepts head

## Operation
- Decode: selected when mem_addr[31:4] == BASE_ADDR[31:4]; word offset = mem_addr[3:2]. Unselected requests are ignored: no mem_ready, no state change.
- Offset 0, TOHOST:
  - Write with wdata[0]=1 and done=0 sets done.
  - pass = (wdata == 32'h1).
  - fail_code = wdata[31:1].
  - Writes with wdata[0]=0, or any write while done=1, are ignored; the first verdict is sticky.
  - Read returns {fail_code, done}.
- Offset 1, CHAR:
  - Write pushes wdata[7:0] if the FIFO is not full.
  - A write while full is dropped and sets the sticky overflow flag.
  - Read returns 0.
- Offset 2, STATUS (read-only): {27'b0, overflow, full, empty, pass, done}. Writes ignored.
- Offset 3, CLEAR: write of any value clears done, pass, fail_code, overflow and flushes the FIFO. Reads return 0.
- FIFO: circular buffer with a log2(FIFO_DEPTH)+1-bit count.
  - char_valid = !empty; char_data = head entry, combinational from storage.
  - Pop when char_valid && char_ready.
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged, no overflow.
  - Push and pop on an empty FIFO: pop does nothing (char_valid=0), push succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- CLEAR in the same cycle as a pop: CLEAR wins, FIFO ends empty.

## Timing
- Reset (asynchronous assert, synchronous release):
  - done=0, pass=0, fail_code=0, overflow=0, FIFO empty, char_valid=0.
  - mem_ready=0, mem_rdata=0.
- Bus: a selected request in cycle N gives mem_ready=1 in cycle N+1, registered, for one cycle.
  - mem_rdata is valid in the same cycle as mem_ready and is 0 otherwise.
  - Back-to-back requests are accepted every cycle.
- Register updates (done/pass/FIFO write) take effect at the clock edge that samples the request; flags and STATUS show them from cycle N+1.
- Pushed byte is visible on char_data/char_valid in cycle N+1.
- Reset mid-operation drops any pending mem_ready and FIFO contents immediately.

## Structure
- Shared SoC package: TOHOST/CHAR/STATUS/CLEAR offset constants and STATUS bit positions, so firmware headers and benches share them.
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, head data), reusable by the future UART TX.
- Top level holds the decode, verdict registers and bus response.

## Test plan
- Reset then write TOHOST=32'h1 → done=1, pass=1 from the next cycle; read TOHOST → 32'h0000_0001.
- Write TOHOST=32'h0000_0007, then TOHOST=32'h1 → done=1, pass=0, fail_code=3; second write ignored.
- Push 'O','K' with char_ready=0 → char_valid=1, char_data=8'h4F; raise char_ready → 8'h4F then 8'h4B, then char_valid=0.
- Push 9 bytes with char_ready=0 (depth 8) → STATUS = 32'h0000_0018 (full, overflow); the 9th byte never appears; drain yields exactly 8 bytes in order.
- Full FIFO with simultaneous push and pop → count stays 8, overflow stays 0, order preserved.
- Write CLEAR after a failing verdict with 3 bytes buffered → STATUS reads 32'h0000_0004 (empty only). Then assert reset_n=0 during an in-flight read → mem_ready=0 immediately.
